// File: rtl/uart_rx_pkg.sv
// Shared types and limits for the UART receive deserializer.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int DATA_W_MIN = 5;
  localparam int DATA_W_MAX = 9;
  localparam int CNT_W = $clog2(DATA_W_MAX);

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;

endpackage

// File: rtl/uart_rx_deser_param_if.sv
// Output word handshake between the deserializer and its consumer.
interface uart_rx_deser_param_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] p_data;
  logic out_valid;
  logic out_ready;
  logic stop_err;
  logic par_err;
  logic overrun;

  modport master (
    output p_data, out_valid, stop_err,
    output par_err, overrun,
    input out_ready
  );

  modport slave (
    input p_data, out_valid, stop_err,
    input par_err, overrun,
    output out_ready
  );
endinterface

// File: rtl/uart_rx_out_buf.sv
// One-entry valid/ready hold register for a received word.
module uart_rx_out_buf #(
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic rst,
  input logic commit,
  input logic [DATA_W-1:0] c_data,
  input logic c_stop_err,
  input logic c_par_err,
  uart_rx_deser_param_if.master ob
);

  logic take;
  logic drop;

  // A held word leaving this cycle frees the slot for the new one.
  assign take = commit &&
    (!ob.out_valid || ob.out_ready);
  assign drop = commit &&
    ob.out_valid && !ob.out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ob.p_data <= '0;
      ob.out_valid <= 1'b0;
      ob.stop_err <= 1'b0;
      ob.par_err <= 1'b0;
      ob.overrun <= 1'b0;
    end else begin
      ob.overrun <= drop;
      if (take) begin
        ob.p_data <= c_data;
        ob.stop_err <= c_stop_err;
        ob.par_err <= c_par_err;
        ob.out_valid <= 1'b1;
      end else if (ob.out_valid && ob.out_ready) begin
        ob.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_rx_deser_param.sv
// UART receive deserializer: frame FSM and shift register.
// Optional parity bit enabled by UART_RX_PARITY_EN.
module uart_rx_deser_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic clk,
  input logic rst,
  input logic deser_en,
  input logic start_stb,
  input logic sample_stb,
  input logic sampled_bit,
  input logic par_odd,
  output logic busy,
  uart_rx_deser_param_if.master rx
);

  rx_state_t state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] idx;
  logic [DATA_W-1:0] shreg;
  logic last;
  logic commit;
  logic c_par_err;

  assign idx = LSB_FIRST ? cnt
    : CNT_W'(DATA_W - 1) - cnt;
  assign last = (cnt == CNT_W'(DATA_W - 1));
  assign busy = (state != IDLE);
  assign commit = deser_en && sample_stb &&
    (state == STOP);

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  // Even parity expects XOR(data); odd expects its inverse.
  assign c_par_err =
    par_bit != ((^shreg) ^ (par_odd == PAR_ODD));
`else
  logic unused_par_odd;
  assign unused_par_odd = par_odd;
  assign c_par_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      shreg <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else if (!deser_en) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_stb) begin
            state <= DATA;
            cnt <= '0;
            shreg <= '0;
          end
        end
        DATA: begin
          if (sample_stb) begin
            for (int i = 0; i < DATA_W; i++) begin
              if (idx == CNT_W'(i)) begin
                shreg[i] <= sampled_bit;
              end
            end
            cnt <= cnt + 1'b1;
            if (last) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
        PARITY: begin
          if (sample_stb) begin
`ifdef UART_RX_PARITY_EN
            par_bit <= sampled_bit;
`endif
            state <= STOP;
          end
        end
        STOP: begin
          if (sample_stb) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_rx_out_buf #(
    .DATA_W(DATA_W)
  ) u_out_buf (
    .clk(clk),
    .rst(rst),
    .commit(commit),
    .c_data(shreg),
    .c_stop_err(~sampled_bit),
    .c_par_err(c_par_err),
    .ob(rx)
  );

endmodule

// File: tb/tb_uart_rx_deser_param.sv
// Scoreboard bench: LSB- and MSB-first instances fed the same bit stream.
module tb_uart_rx_deser_param;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic se;
    logic pe;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic deser_en = 1'b0;
  logic start_stb = 1'b0;
  logic sample_stb = 1'b0;
  logic sampled_bit = 1'b0;
  logic par_odd = 1'b0;
  logic out_ready = 1'b0;
  logic busy_l, busy_m;
  bit rnd_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  exp_t q_l[$];
  exp_t q_m[$];
  exp_t stim_l, stim_m;
  logic stim_commit = 1'b0;
  logic mv, eo;
  logic pv_l, pr_l, pv_m, pr_m;

  always #5 clk = ~clk;

  uart_rx_deser_param_if #(.DATA_W(W)) if_l ();
  uart_rx_deser_param_if #(.DATA_W(W)) if_m ();
  assign if_l.out_ready = out_ready;
  assign if_m.out_ready = out_ready;

  uart_rx_deser_param #(.DATA_W(W), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst(rst), .deser_en(deser_en),
    .start_stb(start_stb), .sample_stb(sample_stb),
    .sampled_bit(sampled_bit), .par_odd(par_odd),
    .busy(busy_l), .rx(if_l.master)
  );

  uart_rx_deser_param #(.DATA_W(W), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst(rst), .deser_en(deser_en),
    .start_stb(start_stb), .sample_stb(sample_stb),
    .sampled_bit(sampled_bit), .par_odd(par_odd),
    .busy(busy_m), .rx(if_m.master)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference for the one-entry output buffer.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mv <= 1'b0;
      eo <= 1'b0;
    end else begin
      eo <= 1'b0;
      if (stim_commit && (!mv || out_ready)) begin
        mv <= 1'b1;
        q_l.push_back(stim_l);
        q_m.push_back(stim_m);
      end else if (stim_commit) begin
        eo <= 1'b1;
      end else if (mv && out_ready) begin
        mv <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("valid_l", if_l.out_valid, mv);
      check("valid_m", if_m.out_valid, mv);
      check("overrun_l", if_l.overrun, eo);
      check("overrun_m", if_m.overrun, eo);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst && if_l.out_valid && (!pv_l || pr_l)) begin
      if (q_l.size() == 0) begin
        check("spurious_word_l", 1, 0);
      end else begin
        e = q_l.pop_front();
        check("p_data_l", if_l.p_data, e.d);
        check("stop_err_l", if_l.stop_err, e.se);
        check("par_err_l", if_l.par_err, e.pe);
      end
    end
    pv_l <= if_l.out_valid;
    pr_l <= out_ready;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst && if_m.out_valid && (!pv_m || pr_m)) begin
      if (q_m.size() == 0) begin
        check("spurious_word_m", 1, 0);
      end else begin
        e = q_m.pop_front();
        check("p_data_m", if_m.p_data, e.d);
        check("stop_err_m", if_m.stop_err, e.se);
        check("par_err_m", if_m.par_err, e.pe);
      end
    end
    pv_m <= if_m.out_valid;
    pr_m <= out_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    stim_commit = 1'b0;
    if (rnd_ready) out_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic samp(input logic b);
    sample_stb = 1'b1;
    sampled_bit = b;
    tick();
    sample_stb = 1'b0;
    sampled_bit = ($urandom_range(0, 1) == 1);
  endtask

  // Gaps inside a frame; start_stb here must be ignored.
  task automatic gap(input int n);
    repeat (n) begin
      start_stb = ($urandom_range(0, 3) == 0);
      sample_stb = 1'b0;
      tick();
    end
    start_stb = 1'b0;
  endtask

  // Idle cycles; stray sample_stb here must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      sample_stb = ($urandom_range(0, 3) == 0);
      tick();
    end
    sample_stb = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] w,
                            input logic stop,
                            input logic pbit,
                            input int abort_at,
                            input int rdy_stop,
                            input int gmax);
    logic [W-1:0] m;
    logic pe;
    start_stb = 1'b1;
    tick();
    start_stb = 1'b0;
    check("busy_after_start", {busy_l, busy_m}, 2'b11);
    for (int k = 0; k < W; k++) begin
      gap($urandom_range(0, gmax));
      if (k == abort_at) begin
        deser_en = 1'b0;
        tick();
        deser_en = 1'b1;
        check("busy_after_abort", {busy_l, busy_m}, 2'b00);
        return;
      end
      samp(w[k]);
    end
`ifdef UART_RX_PARITY_EN
    gap($urandom_range(0, gmax));
    samp(pbit);
    pe = (pbit != ((^w) ^ par_odd));
`else
    pe = 1'b0 & pbit;
`endif
    gap($urandom_range(0, gmax));
    for (int k = 0; k < W; k++) m[W-1-k] = w[k];
    stim_l = '{d: w, se: !stop, pe: pe};
    stim_m = '{d: m, se: !stop, pe: pe};
    stim_commit = 1'b1;
    if (rdy_stop >= 0) out_ready = (rdy_stop != 0);
    samp(stop);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_p_data_l"}, if_l.p_data, 0);
    check({tag, "_p_data_m"}, if_m.p_data, 0);
    check({tag, "_valid"},
          {if_l.out_valid, if_m.out_valid}, 0);
    check({tag, "_stop_err"},
          {if_l.stop_err, if_m.stop_err}, 0);
    check({tag, "_par_err"},
          {if_l.par_err, if_m.par_err}, 0);
    check({tag, "_overrun"},
          {if_l.overrun, if_m.overrun}, 0);
    check({tag, "_busy"}, {busy_l, busy_m}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w;
    int ab;
    deser_en = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b1;
    tick();

    send_frame(8'hA5, 1'b1, 1'b0, -1, -1, 0);
    idle(3);
    send_frame(8'h3C, 1'b0, 1'b0, -1, -1, 1);
    idle(3);

    out_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, -1, -1, 1);
    idle(2);
    send_frame(8'h22, 1'b1, 1'b0, -1, -1, 1);
    idle(2);
    send_frame(8'h33, 1'b1, 1'b0, -1, 1, 1);
    idle(3);

    send_frame(8'hC3, 1'b1, 1'b0, 4, -1, 1);
    send_frame(8'h5A, 1'b1, 1'b0, -1, -1, 1);
    idle(3);

    par_odd = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1, -1, -1, 0);
    idle(2);
    send_frame(8'h07, 1'b1, 1'b0, -1, -1, 0);
    idle(2);
    par_odd = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0, -1, -1, 0);
    idle(2);
    par_odd = 1'b0;

    out_ready = 1'b0;
    send_frame(8'h6B, 1'b0, 1'b0, -1, -1, 0);
    idle(2);
    start_stb = 1'b1;
    tick();
    start_stb = 1'b0;
    samp(1'b1);
    samp(1'b0);
    samp(1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk_reset("midrst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    tick();

    rnd_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      w = W'($urandom);
      par_odd = ($urandom_range(0, 1) == 1);
      ab = ($urandom_range(0, 9) == 0)
        ? int'($urandom_range(0, W - 1)) : -1;
      send_frame(w, ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 1) == 1), ab, -1, 2);
      idle($urandom_range(0, 3));
    end

    rnd_ready = 1'b0;
    out_ready = 1'b1;
    idle(4);
    check("queue_empty_l", q_l.size(), 0);
    check("queue_empty_m", q_m.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
